// File: rtl/sdram_req_arbiter_if.sv
// Request, command-FIFO write and read-response bundle of sdram_req_arbiter.
// slave: arbiter side; master: client/controller side.
interface sdram_req_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int ADDR_W  = 24,
    parameter int DATA_W  = 16
);
    // client request ports, flattened per port
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_ready;

    // command FIFO write side
    logic                           fifo_full;
    logic                           fifo_w_en;
    logic [ID_W+1+ADDR_W+DATA_W-1:0] fifo_din;

    // read responses from the controller and back to the ports
    logic              rsp_valid;
    logic [ID_W-1:0]   rsp_id;
    logic [DATA_W-1:0] rsp_data;
    logic [NUM_REQ-1:0] rsp_valid_o;
    logic [DATA_W-1:0] rsp_data_o;
    logic              err_underflow;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        input  fifo_full,
        input  rsp_valid, rsp_id, rsp_data,
        output req_ready, fifo_w_en, fifo_din,
        output rsp_valid_o, rsp_data_o, err_underflow
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        output fifo_full,
        output rsp_valid, rsp_id, rsp_data,
        input  req_ready, fifo_w_en, fifo_din,
        input  rsp_valid_o, rsp_data_o, err_underflow
    );
endinterface

// File: rtl/sdram_req_arbiter.sv
// Round-robin arbiter sharing the SDRAM command FIFO between NUM_REQ ports,
// with per-port outstanding-read throttling and ID-routed read responses.
// Ports: clk, rst_n (sync, active-low), bus (sdram_req_arbiter_if.slave):
//   req_* in / req_ready out, fifo_full in / fifo_w_en+fifo_din out,
//   rsp_* in / rsp_valid_o, rsp_data_o, err_underflow out.
module sdram_req_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int ADDR_W  = 24,
    parameter int DATA_W  = 16,
    parameter int MAX_OUT = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sdram_req_arbiter_if.slave    bus
);
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  out_cnt_q [NUM_REQ];
    logic [CNT_W-1:0]  out_cnt_d [NUM_REQ];
    logic [NUM_REQ-1:0] rsp_valid_o_q, rsp_valid_o_d;
    logic [DATA_W-1:0] rsp_data_o_q, rsp_data_o_d;
    logic              err_underflow_q, err_underflow_d;

    logic [NUM_REQ-1:0] eligible;
    logic               found;
    logic [ID_W-1:0]    winner;
    logic [ID_W-1:0]    idx;
    logic               transfer;
    logic               sel_we;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic [NUM_REQ-1:0] ready;

    // Reads need a free outstanding slot; writes are never throttled.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = bus.req_valid[i] &&
                          (bus.req_we[i] || (out_cnt_q[i] < MAX_CNT));
        end
    end

    // Scan from rr_ptr upward; ID_W-bit addition wraps modulo NUM_REQ.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = rr_ptr_q + ID_W'(k);
            if (!found && eligible[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign transfer = found && !bus.fifo_full;

    // Select the winning port's fields.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == ID_W'(i)) begin
                sel_we    = bus.req_we[i];
                sel_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        ready = '0;
        if (transfer) begin
            ready[winner] = 1'b1;
        end
    end

    assign bus.req_ready = ready;
    assign bus.fifo_w_en = transfer;
    assign bus.fifo_din  = transfer ? {winner, sel_we, sel_addr, sel_wdata}
                                    : '0;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (transfer) begin
            rr_ptr_d = winner + ID_W'(1);
        end
    end

    // Response routing: registered, never back-pressured.
    always_comb begin
        rsp_valid_o_d = '0;
        rsp_data_o_d  = rsp_data_o_q;
        if (bus.rsp_valid) begin
            rsp_valid_o_d[bus.rsp_id] = 1'b1;
            rsp_data_o_d              = bus.rsp_data;
        end
    end

    // Outstanding-read counters. A simultaneous issue and return cancel.
    always_comb begin
        logic inc;
        logic dec;
        err_underflow_d = err_underflow_q;
        inc = 1'b0;
        dec = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            out_cnt_d[i] = out_cnt_q[i];
            inc = transfer && (winner == ID_W'(i)) && !bus.req_we[i];
            dec = bus.rsp_valid && (bus.rsp_id == ID_W'(i));
            if (inc && !dec) begin
                out_cnt_d[i] = out_cnt_q[i] + CNT_W'(1);
            end else if (!inc && dec) begin
                if (out_cnt_q[i] != '0) begin
                    out_cnt_d[i] = out_cnt_q[i] - CNT_W'(1);
                end else begin
                    err_underflow_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q        <= '0;
            rsp_valid_o_q   <= '0;
            rsp_data_o_q    <= '0;
            err_underflow_q <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                out_cnt_q[i] <= '0;
            end
        end else begin
            rr_ptr_q        <= rr_ptr_d;
            rsp_valid_o_q   <= rsp_valid_o_d;
            rsp_data_o_q    <= rsp_data_o_d;
            err_underflow_q <= err_underflow_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                out_cnt_q[i] <= out_cnt_d[i];
            end
        end
    end

    assign bus.rsp_valid_o   = rsp_valid_o_q;
    assign bus.rsp_data_o    = rsp_data_o_q;
    assign bus.err_underflow = err_underflow_q;

endmodule

// File: doc/sdram_req_arbiter.md
Name: sdram_req_arbiter

Overview:
Round-robin arbiter that shares the SDRAM command FIFO (synch_fifo instance, write side) between NUM_REQ client ports. Each granted request is tagged with its port ID and written into the FIFO in the same cycle. Per-port outstanding-read counters throttle reads. Read responses returned by the SDRAM controller are routed back to the issuing port by ID.

Parameters:
NUM_REQ, 4, number of requester ports; legal values 2, 4, 8.
ID_W, 2, port-ID width; must equal log2(NUM_REQ).
ADDR_W, 24, request address width.
DATA_W, 16, write and read data width.
MAX_OUT, 2, maximum outstanding reads per port; range 1..15.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset; synchronous, active-low
req_valid  in  NUM_REQ  per-port request valid
req_we  in  NUM_REQ  per-port write enable; 1 = write, 0 = read
req_addr  in  NUM_REQ*ADDR_W  port i address at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  port i write data at [i*DATA_W +: DATA_W]
req_ready  out  NUM_REQ  one-hot grant, combinational
fifo_full  in  1  command FIFO full flag
fifo_w_en  out  1  command FIFO write enable, combinational
fifo_din  out  ID_W+1+ADDR_W+DATA_W  packed as {id, we, addr, wdata}
rsp_valid  in  1  read response valid from the SDRAM controller
rsp_id  in  ID_W  ID of the port that issued the read
rsp_data  in  DATA_W  read data
rsp_valid_o  out  NUM_REQ  one-hot per-port response valid, registered
rsp_data_o  out  DATA_W  response data shared by all ports, registered
err_underflow  out  1  sticky flag: response received for a port with zero outstanding reads

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - rr_ptr=0; all out_cnt=0.
  - rsp_valid_o=0, rsp_data_o=0, err_underflow=0.
  - Reset mid-operation discards outstanding counts; combinational outputs follow inputs with cleared state.
- Eligibility: eligible[i] = req_valid[i] && (req_we[i] || out_cnt[i] < MAX_OUT). out_cnt is the value at the start of the cycle.
- Grant:
  - Issued only when fifo_full=0 and at least one port is eligible.
  - Winner = first eligible port scanning rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - req_ready = one-hot(winner); otherwise req_ready=0.
  - At most one ready bit is set per cycle. Ready never asserts for a non-valid port.
- Transfer = grant in a cycle; zero latency:
  - fifo_w_en = transfer.
  - fifo_din = {winner, req_we[w], req_addr[w], req_wdata[w]}.
  - fifo_din = 0 when there is no transfer.
- rr_ptr update: on transfer, rr_ptr <= (winner+1) mod NUM_REQ. Otherwise rr_ptr holds, including while fifo_full=1.
- Response path, registered with one cycle latency:
  - rsp_valid_o <= rsp_valid ? one-hot(rsp_id) : 0.
  - rsp_data_o <= rsp_valid ? rsp_data : rsp_data_o.
  - Responses are always forwarded. There is no back-pressure on the response side.
- Counters, per port i:
  - inc = transfer to i with we=0.
  - dec = rsp_valid && rsp_id==i.
  - inc && dec: unchanged. inc only: +1. dec only: -1 if out_cnt[i]>0.
  - dec with out_cnt[i]==0: counter stays 0 and err_underflow <= 1.
  - err_underflow clears only on reset.
- A rsp_id >= NUM_REQ is impossible by construction, since ID_W = log2(NUM_REQ).
- Writes are never throttled by out_cnt.

Test Plan:
1. Single write. Port 2: valid, we=1, addr=0x000123, wdata=0xBEEF; fifo_full=0 -> same cycle req_ready=4'b0100, fifo_w_en=1, fifo_din={2'd2,1'b1,24'h000123,16'hBEEF}; next cycle rr_ptr=3.
2. Fairness. All four ports hold valid writes for 5 cycles -> grants 0,1,2,3,0; exactly one fifo_w_en per cycle.
3. Back-pressure. Ports 1 and 3 valid with fifo_full=1 for 3 cycles -> req_ready=0, fifo_w_en=0, rr_ptr unchanged. Drop full -> port 1 granted first (rr_ptr=0), then port 3.
4. Throttle. MAX_OUT=2; port 1 issues 3 reads with no responses -> third read held (req_ready[1]=0) while port 0 writes are still granted. Then rsp_valid with id=1, data=0x5A5A -> next cycle rsp_valid_o=4'b0010, rsp_data_o=0x5A5A, out_cnt[1]=1; held read granted in that same cycle.
5. Same-cycle events. out_cnt[0]=1; read grant to port 0 and rsp_valid with id=0 in the same cycle -> out_cnt[0] stays 1; rsp_valid_o=4'b0001 next cycle.
6. Underflow and reset. rsp_valid with id=3 while out_cnt[3]=0 -> rsp_valid_o=4'b1000 and err_underflow=1, held high. Assert rst_n=0 for one edge mid-traffic -> all counters 0, err_underflow=0, rr_ptr=0; next grant goes to the lowest-index valid port.
